cmp_width_meter: RTL and testbench

- Multi-channel successor to the single RC-comparator pulse-width wrapper.
- Measures the high-time, in clk cycles, of NUM_CH asynchronous comparator outputs.
- Filters glitches and buffers one result per channel.
- Streams results through a single valid/ready port under round-robin arbitration, to the downstream logger/checker.

---
 rtl/cmp_width_meter.sv | 238 +++++++++++++++++++++++
 tb/tb_cmp_width_meter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_width_meter.sv
// Multi-channel comparator pulse-width meter: synchronises each comparator, measures its
// high-time in clk cycles, buffers one result per channel and streams results round-robin.
module cmp_width_meter #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_WIDTH   = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MIN_WIDTH   = 1,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic [NUM_CH-1:0]    cmp_in_i,
   input  logic                 clr_drop_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [CH_W-1:0]      out_ch_o,
   output logic [CNT_WIDTH-1:0] out_width_o,
   output logic                 out_sat_o,
   output logic [NUM_CH-1:0]    drop_o
);

   typedef enum logic [1:0] {StIdle, StArmed, StCount} ch_state_e;

   localparam logic [CNT_WIDTH-1:0] MinCnt = CNT_WIDTH'(MIN_WIDTH);
   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
   localparam logic [CH_W-1:0]      LastCh = CH_W'(NUM_CH - 1);

   logic [NUM_CH-1:0]      sync_q [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] prime_q;
   logic [NUM_CH-1:0]      s_prev_q;
   logic [NUM_CH-1:0]      s;
   logic [NUM_CH-1:0]      rise;
   logic [NUM_CH-1:0]      fall;
   logic                   primed;

   assign s      = sync_q[SYNC_STAGES-1];
   assign rise   = s & ~s_prev_q;
   assign fall   = ~s & s_prev_q;
   // Synchroniser output is only trusted once it has been refilled after reset, so a
   // pulse already high at reset release cannot look like a fresh rising edge.
   assign primed = &prime_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         prime_q  <= '0;
         s_prev_q <= '0;
      end else begin
         sync_q[0] <= cmp_in_i;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         prime_q  <= {prime_q[SYNC_STAGES-2:0], 1'b1};
         s_prev_q <= s;
      end
   end

   ch_state_e            state_q [NUM_CH];
   ch_state_e            state_d [NUM_CH];
   logic [CNT_WIDTH-1:0] cnt_q   [NUM_CH];
   logic [CNT_WIDTH-1:0] cnt_d   [NUM_CH];
   logic [NUM_CH-1:0]    sat_q;
   logic [NUM_CH-1:0]    sat_d;
   logic [NUM_CH-1:0]    offer;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= StIdle;
            cnt_q[i]   <= '0;
         end
         sat_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         sat_q <= sat_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         if (!en_i) begin
            state_d[i] = StIdle;
         end else begin
            unique case (state_q[i])
               StIdle:  if (primed && !s[i]) state_d[i] = StArmed;
               StArmed: if (rise[i]) state_d[i] = StCount;
               StCount: if (fall[i]) state_d[i] = StArmed;
               default: state_d[i] = StIdle;
            endcase
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         sat_d[i] = sat_q[i];
         offer[i] = 1'b0;
         if (!en_i) begin
            cnt_d[i] = '0;
            sat_d[i] = 1'b0;
         end else if (state_q[i] == StArmed && rise[i]) begin
            cnt_d[i] = CntOne;
            sat_d[i] = 1'b0;
         end else if (state_q[i] == StCount) begin
            if (fall[i]) begin
               offer[i] = (cnt_q[i] >= MinCnt);
            end else if (cnt_q[i] == '1) begin
               sat_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CntOne;
            end
         end
      end
   end

   logic [NUM_CH-1:0]    slot_full_q;
   logic [NUM_CH-1:0]    slot_full_d;
   logic [NUM_CH-1:0]    slot_sat_q;
   logic [NUM_CH-1:0]    slot_sat_d;
   logic [CNT_WIDTH-1:0] slot_width_q [NUM_CH];
   logic [CNT_WIDTH-1:0] slot_width_d [NUM_CH];
   logic [NUM_CH-1:0]    drop_q;
   logic [NUM_CH-1:0]    drop_d;
   logic [NUM_CH-1:0]    drop_set;
   logic [NUM_CH-1:0]    pop;

   // A pop in the same cycle frees the slot, so a simultaneous offer is never dropped.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         slot_full_d[i]  = slot_full_q[i];
         slot_sat_d[i]   = slot_sat_q[i];
         slot_width_d[i] = slot_width_q[i];
         drop_set[i]     = 1'b0;
         if (offer[i]) begin
            if (!slot_full_q[i] || pop[i]) begin
               slot_full_d[i]  = 1'b1;
               slot_sat_d[i]   = sat_q[i];
               slot_width_d[i] = cnt_q[i];
            end else begin
               drop_set[i] = 1'b1;
            end
         end else if (pop[i]) begin
            slot_full_d[i] = 1'b0;
         end
      end
      drop_d = drop_set | (drop_q & ~{NUM_CH{clr_drop_i}});
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_full_q <= '0;
         slot_sat_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) slot_width_q[i] <= '0;
         drop_q      <= '0;
      end else begin
         slot_full_q <= slot_full_d;
         slot_sat_q  <= slot_sat_d;
         for (int i = 0; i < NUM_CH; i++) slot_width_q[i] <= slot_width_d[i];
         drop_q      <= drop_d;
      end
   end

   logic                 out_valid_q;
   logic                 out_valid_d;
   logic                 out_sat_q;
   logic                 out_sat_d;
   logic [CH_W-1:0]      out_ch_q;
   logic [CH_W-1:0]      out_ch_d;
   logic [CNT_WIDTH-1:0] out_width_q;
   logic [CNT_WIDTH-1:0] out_width_d;
   logic [CH_W-1:0]      ptr_q;
   logic [CH_W-1:0]      ptr_d;
   logic [CH_W-1:0]      grant;
   logic [CH_W-1:0]      idx;
   logic                 grant_vld;
   logic                 load;

   assign load = ~out_valid_q | out_ready_i;

   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      idx       = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         idx = CH_W'((32'(ptr_q) + k) % NUM_CH);
         if (!grant_vld && slot_full_q[idx]) begin
            grant_vld = 1'b1;
            grant     = idx;
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      out_width_d = out_width_q;
      out_sat_d   = out_sat_q;
      ptr_d       = ptr_q;
      pop         = '0;
      if (load) begin
         out_valid_d = grant_vld;
         if (grant_vld) begin
            out_ch_d    = grant;
            out_width_d = slot_width_q[grant];
            out_sat_d   = slot_sat_q[grant];
            ptr_d       = (grant == LastCh) ? '0 : grant + 1'b1;
            pop[grant]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_width_q <= '0;
         out_sat_q   <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         out_width_q <= out_width_d;
         out_sat_q   <= out_sat_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_ch_o    = out_ch_q;
   assign out_width_o = out_width_q;
   assign out_sat_o   = out_sat_q;
   assign drop_o      = drop_q;

endmodule

// File: tb/tb_cmp_width_meter.sv
// Bench for cmp_width_meter: pulse vector table plus hand-written arbitration,
// back-pressure, enable and reset sequences, all checked through a beat scoreboard.
module tb_cmp_width_meter;

   localparam int unsigned NumCh = 4;
   localparam int unsigned CntW  = 4;
   localparam int unsigned MinW  = 3;

   logic            clk;
   logic            rst_n;
   logic            en;
   logic [NumCh-1:0] cmp_in;
   logic            clr_drop;
   logic            out_valid;
   logic            out_ready;
   logic [1:0]      out_ch;
   logic [CntW-1:0] out_width;
   logic            out_sat;
   logic [NumCh-1:0] drop;

   typedef struct {
      int ch;
      int width;
      bit sat;
   } exp_t;

   typedef struct {
      int ch;
      int len;
      bit emits;
      int width;
      bit sat;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[8];
   int   n_cmp  = 0;
   int   n_fail = 0;

   cmp_width_meter #(
      .NUM_CH      (NumCh),
      .CNT_WIDTH   (CntW),
      .SYNC_STAGES (2),
      .MIN_WIDTH   (MinW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (en),
      .cmp_in_i    (cmp_in),
      .clr_drop_i  (clr_drop),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_ch_o    (out_ch),
      .out_width_o (out_width),
      .out_sat_o   (out_sat),
      .drop_o      (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // One clock cycle: score any handshake at the falling edge, return just after the rise.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got ch=%0d width=%0d, expected no beat",
                     out_ch, out_width);
         end else begin
            e = exp_q.pop_front();
            check("beat_ch", 32'(out_ch), e.ch);
            check("beat_width", 32'(out_width), e.width);
            check("beat_sat", 32'(out_sat), 32'(e.sat));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic expect_beat(input int ch, input int width, input bit sat);
      exp_t e;
      e.ch    = ch;
      e.width = width;
      e.sat   = sat;
      exp_q.push_back(e);
   endtask

   task automatic drive_pulse(input int ch, input int len);
      cmp_in[ch] = 1'b1;
      repeat (len) tick();
      cmp_in[ch] = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1, 2, 1'b0, 0, 1'b0};
      vecs[1] = '{1, 3, 1'b1, 3, 1'b0};
      vecs[2] = '{2, 20, 1'b1, 15, 1'b1};
      vecs[3] = '{2, 5, 1'b1, 5, 1'b0};
      vecs[4] = '{3, 15, 1'b1, 15, 1'b0};
      vecs[5] = '{3, 16, 1'b1, 15, 1'b1};
      vecs[6] = '{0, 1, 1'b0, 0, 1'b0};
      vecs[7] = '{3, 7, 1'b1, 7, 1'b0};

      rst_n     = 1'b0;
      en        = 1'b1;
      cmp_in    = 4'b0001;
      clr_drop  = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      check("rst_valid", 32'(out_valid), 0);
      check("rst_ch", 32'(out_ch), 0);
      check("rst_width", 32'(out_width), 0);
      check("rst_sat", 32'(out_sat), 0);
      check("rst_drop", 32'(drop), 0);

      // ch0 already high at reset release: only the later 7-cycle pulse counts.
      rst_n = 1'b1;
      repeat (5) tick();
      cmp_in[0] = 1'b0;
      repeat (5) tick();
      expect_beat(0, 7, 1'b0);
      drive_pulse(0, 7);
      repeat (6) tick();

      // Latency: beat appears on the fourth clock after the raw input falls.
      expect_beat(0, 10, 1'b0);
      drive_pulse(0, 10);
      repeat (3) tick();
      check("lat_early_idle", 32'(out_valid), 0);
      tick();
      check("lat_valid", 32'(out_valid), 1);
      check("lat_width", 32'(out_width), 10);
      repeat (4) tick();

      for (int v = 0; v < 8; v++) begin
         if (vecs[v].emits) expect_beat(vecs[v].ch, vecs[v].width, vecs[v].sat);
         drive_pulse(vecs[v].ch, vecs[v].len);
         repeat (6) tick();
      end
      check("short_no_drop", 32'(drop), 0);

      for (int r = 0; r < 2; r++) begin
         if (r == 1) begin
            expect_beat(1, 3, 1'b0);
            drive_pulse(1, 3);
            repeat (6) tick();
         end
         for (int c = 0; c < 4; c++) expect_beat((2 * r + c) % 4, 4, 1'b0);
         cmp_in = 4'b1111;
         repeat (4) tick();
         cmp_in = 4'b0000;
         repeat (4) tick();
         for (int c = 0; c < 4; c++) begin
            check("rr_valid", 32'(out_valid), 1);
            check("rr_order", 32'(out_ch), (2 * r + c) % 4);
            tick();
         end
         repeat (3) tick();
      end

      out_ready = 1'b0;
      expect_beat(1, 4, 1'b0);
      drive_pulse(1, 4);
      repeat (4) tick();
      expect_beat(1, 6, 1'b0);
      drive_pulse(1, 6);
      repeat (4) tick();
      drive_pulse(1, 8);
      repeat (4) tick();
      check("bp_valid", 32'(out_valid), 1);
      check("bp_hold_ch", 32'(out_ch), 1);
      check("bp_hold_width", 32'(out_width), 4);
      check("bp_drop", 32'(drop), 32'h2);
      out_ready = 1'b1;
      repeat (5) tick();
      check("bp_drained", 32'(out_valid), 0);
      check("drop_sticky", 32'(drop), 32'h2);
      clr_drop = 1'b1;
      tick();
      clr_drop = 1'b0;
      check("drop_cleared", 32'(drop), 0);

      // Disabling mid-pulse abandons the measurement.
      cmp_in[2] = 1'b1;
      repeat (4) tick();
      en = 1'b0;
      repeat (2) tick();
      cmp_in[2] = 1'b0;
      repeat (3) tick();
      en = 1'b1;
      repeat (6) tick();
      check("en_abandon", 32'(out_valid), 0);
      expect_beat(2, 5, 1'b0);
      drive_pulse(2, 5);
      repeat (6) tick();

      // Reset with a beat held at the output and ch3 mid-pulse.
      out_ready = 1'b0;
      drive_pulse(0, 5);
      for (int k = 0; k < 20 && !out_valid; k++) tick();
      check("rst_pre_valid", 32'(out_valid), 1);
      cmp_in[3] = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(out_valid), 0);
      check("rst_mid_width", 32'(out_width), 0);
      check("rst_mid_drop", 32'(drop), 0);
      repeat (2) tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (4) tick();
      cmp_in[3] = 1'b0;
      repeat (10) tick();
      check("post_rst_idle", 32'(out_valid), 0);

      for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
      check("sb_empty", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
